toggle_debounce: RTL

Upstream conditioning stage for the T flip-flop. Takes a raw, asynchronous, bouncing push-button level and produces a clean single-cycle `t_out` pulse per press, sized to drive a T flip-flop's `T` input directly. Optional auto-repeat emits further pulses while the button is held. Also exports the debounced button level for status and LEDs.

---
 rtl/toggle_debounce.sv | 134 +++++++++++++
 1 files changed

// File: rtl/toggle_debounce.sv
// toggle_debounce: conditions a raw, bouncing push-button into a clean
// one-cycle t_out pulse per press (with optional auto-repeat while held),
// and exports the debounced button level.
module toggle_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic t_out,
    output logic btn_level
);

    // Counters are sized for the largest terminal count they ever approach.
    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    state_t           state;
    logic             s1;
    logic             btn_sync;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             first;

    // Synchronizer, debounce/repeat FSM and registered outputs in one process.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 1'b0;
            btn_sync  <= 1'b0;
            state     <= IDLE;
            db_cnt    <= CNT_ZERO;
            rep_cnt   <= CNT_ZERO;
            first     <= 1'b0;
            t_out     <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so the FSM below sees last cycle's btn_sync, not this cycle's s1.
            s1       <= btn_in;
            btn_sync <= s1;
            // NOTE: t_out defaults low each edge; only the branches that issue a pulse override it.
            t_out    <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state     <= HELD;
                            t_out     <= 1'b1;
                            btn_level <= 1'b1;
                            rep_cnt   <= CNT_ZERO;
                            first     <= 1'b1;
                            db_cnt    <= CNT_ZERO;
                        end else begin
                            state  <= PRESS_CHK;
                            db_cnt <= CNT_ONE;
                        end
                    end
                end

                PRESS_CHK: begin
                    if (!btn_sync) begin
                        // Glitch shorter than the debounce window: drop it silently.
                        state  <= IDLE;
                        db_cnt <= CNT_ZERO;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= HELD;
                        t_out     <= 1'b1;
                        btn_level <= 1'b1;
                        rep_cnt   <= CNT_ZERO;
                        first     <= 1'b1;
                        db_cnt    <= CNT_ZERO;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    if (!btn_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state     <= IDLE;
                            btn_level <= 1'b0;
                            db_cnt    <= CNT_ZERO;
                        end else begin
                            state  <= REL_CHK;
                            db_cnt <= CNT_ONE;
                        end
                    end else if (!repeat_en) begin
                        rep_cnt <= CNT_ZERO;
                    end else if (rep_cnt == (first ? RD_LAST : RP_LAST)) begin
                        t_out   <= 1'b1;
                        rep_cnt <= CNT_ZERO;
                        first   <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + CNT_ONE;
                    end
                end

                REL_CHK: begin
                    if (btn_sync) begin
                        // Release bounce: resume HELD with repeat timing untouched.
                        state  <= HELD;
                        db_cnt <= CNT_ZERO;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                        db_cnt    <= CNT_ZERO;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
